reg_datos: RTL and testbench
============================

Name: reg_datos

Overview:
- 32-bit data-capture register that assembles a word from two 8-bit byte sources: internal data `i_int` and external data `i_ext`.
- Each write strobe shifts the selected byte into the least-significant end of the word; older bytes move toward the MSB.
- Sits between byte-wide data producers and a 32-bit consumer. The assembled word is continuously visible on `outD`.

Parameters:
- None. Byte width is fixed at 8; word width is fixed at 32 (4 byte lanes).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- WR1D  input  1  write strobe: shift `i_int` into the word.
- WR2D  input  1  write strobe: shift `i_ext` into the word.
- i_int  input  8  internal data byte.
- i_ext  input  8  external data byte.
- outD  output  32  assembled data word, registered output.

Behaviour:
- One clock domain (`clk`). Reset is asynchronous and active-low.
- While `rst`=0, `outD` = 32'h0000_0000 immediately, independent of `clk`. Strobes are ignored during reset.
- On release of `rst` (0→1), the register holds 0 until the first rising edge with a strobe asserted.
- Reset asserted mid-sequence clears all four byte lanes at once; there is no partial retention.
- At each rising edge of `clk` with `rst`=1, the register updates by priority-free decode:
  - WR1D=0, WR2D=0: hold `outD`.
  - WR1D=1, WR2D=0: `outD` <= {`outD`[23:0], `i_int`}.
  - WR1D=0, WR2D=1: `outD` <= {`outD`[23:0], `i_ext`}.
  - WR1D=1, WR2D=1: `outD` <= {`outD`[15:0], `i_int`, `i_ext`}. Two bytes shift in per cycle, with `i_int` above `i_ext`.
- Latency: one cycle. Data and strobes sampled at edge N appear on `outD` right after edge N.
- Overflow is silent: bytes shifted past bit 31 are discarded. There is no full or empty flag.
- Byte-source inputs are sampled only when their own strobe is high. Changes on a non-strobed input have no effect.
- `outD` is driven directly from flops, with no combinational path from inputs to output.
- X/Z on a strobe is not a supported stimulus. The implementation treats any non-1 strobe value as 0.

Test Plan:
- Reset: hold `rst`=0 with strobes toggling and `i_int`=8'hFF → `outD`=32'h0; assert `rst`=0 between clock edges → `outD` clears immediately.
- Single WR2D: after reset, `i_int`=5, `i_ext`=8, WR2D for one cycle → `outD`=32'h0000_0008; strobe low for the next cycle → `outD` held.
- Single WR1D: from 32'h0000_0008, WR1D for one cycle → 32'h0000_0805; after one idle cycle, WR1D again → 32'h0008_0505.
- Dual strobe: from 32'h0008_0505, WR1D=WR2D=1 → 32'h0505_0508. Then WR2D only → 32'h0505_0808. Then both strobes for two cycles → 32'h0808_0508, then 32'h0508_0508.
- Overflow: four successive WR1D with `i_int`=11,22,33,44, then a fifth with 55 → `outD`=32'h2233_4455; the first byte is discarded.
- Input isolation: with both strobes low, change `i_int` and `i_ext` every cycle for 5 cycles → `outD` unchanged.

Source files
------------

// File: rtl/reg_datos_if.sv
// Byte-write bus into the 32-bit capture register.
// Two strobes select which byte source is shifted in; outD carries the assembled word.
interface reg_datos_if;
  logic        WR1D;
  logic        WR2D;
  logic [7:0]  i_int;
  logic [7:0]  i_ext;
  logic [31:0] outD;

  // Producer side: drives strobes and bytes, observes the word.
  modport master (
    output WR1D,
    output WR2D,
    output i_int,
    output i_ext,
    input  outD
  );

  // Register side: samples strobes and bytes, drives the word.
  modport slave (
    input  WR1D,
    input  WR2D,
    input  i_int,
    input  i_ext,
    output outD
  );
endinterface

// File: rtl/reg_datos.sv
// 32-bit capture register: each strobe shifts a byte in at the LSB end; both strobes
// together shift two bytes (i_int above i_ext). Older bytes fall off the MSB silently.
module reg_datos (
  input  logic        clk,
  input  logic        rst,
  reg_datos_if.slave  bus
);

  logic [31:0] data_q;
  logic [31:0] data_d;
  logic        wr1_s;
  logic        wr2_s;

  // Only a solid 1 counts as a strobe; anything else reads as idle.
  assign wr1_s = (bus.WR1D == 1'b1);
  assign wr2_s = (bus.WR2D == 1'b1);

  always_comb begin
    data_d = data_q;
    case ({wr1_s, wr2_s})
      2'b10:   data_d = {data_q[23:0], bus.i_int};
      2'b01:   data_d = {data_q[23:0], bus.i_ext};
      2'b11:   data_d = {data_q[15:0], bus.i_int, bus.i_ext};
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= 32'h0000_0000;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.outD = data_q;

endmodule

// File: tb/tb_reg_datos.sv
// Randomised and directed bench for reg_datos, scoreboarded against a byte-history model.
module tb_reg_datos;

  logic clk;
  logic rst;
  reg_datos_if bus ();

  reg_datos dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  hist_q[$];

  // Reference: the word is simply the last four bytes written, newest in the low lane.
  function automatic logic [31:0] model_word();
    logic [31:0] w;
    int n;
    w = 32'h0;
    n = hist_q.size();
    for (int k = 0; k < 4; k++) begin
      if (k < n) w = w + (32'(hist_q[n - 1 - k]) << (8 * k));
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w1, input logic w2, input logic [7:0] a, input logic [7:0] b);
    bus.WR1D  = w1;
    bus.WR2D  = w2;
    bus.i_int = a;
    bus.i_ext = b;
    if (w1) hist_q.push_back(a);
    if (w2) hist_q.push_back(b);
    while (hist_q.size() > 4) void'(hist_q.pop_front());
    exp_q.push_back(model_word());
    @(posedge clk);
    #2;
  endtask

  // Monitor: the word is expected one edge after each issued cycle.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("outD", bus.outD, exp_q.pop_front());
  end

  initial begin
    bus.WR1D = 1'b0; bus.WR2D = 1'b0; bus.i_int = 8'h00; bus.i_ext = 8'h00;
    rst = 1'b0;
    #1;
    check("reset_initial", bus.outD, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.WR1D = i[0]; bus.WR2D = i[1]; bus.i_int = 8'hFF; bus.i_ext = 8'hFF;
      @(posedge clk); #1;
      check("reset_held", bus.outD, 32'h0);
    end
    @(negedge clk);
    bus.WR1D = 1'b0; bus.WR2D = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_release_hold", bus.outD, 32'h0);
    #1;

    // Directed sequence
    drive(1'b0, 1'b1, 8'h05, 8'h08);
    drive(1'b0, 1'b0, 8'h05, 8'h08);
    drive(1'b1, 1'b0, 8'h05, 8'h08);
    drive(1'b0, 1'b0, 8'h05, 8'h08);
    drive(1'b1, 1'b0, 8'h05, 8'h08);
    check("single_wr1_seq", bus.outD, 32'h0008_0505);
    drive(1'b1, 1'b1, 8'h05, 8'h08);
    check("dual_first", bus.outD, 32'h0505_0508);
    drive(1'b0, 1'b1, 8'h05, 8'h08);
    drive(1'b1, 1'b1, 8'h05, 8'h08);
    drive(1'b1, 1'b1, 8'h05, 8'h08);
    check("dual_twice", bus.outD, 32'h0508_0508);

    // Overflow: five single writes, oldest byte discarded
    drive(1'b1, 1'b0, 8'h11, 8'h00);
    drive(1'b1, 1'b0, 8'h22, 8'h00);
    drive(1'b1, 1'b0, 8'h33, 8'h00);
    drive(1'b1, 1'b0, 8'h44, 8'h00);
    drive(1'b1, 1'b0, 8'h55, 8'h00);
    check("overflow", bus.outD, 32'h2233_4455);

    // Isolation: idle strobes with churning data
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    check("isolation", bus.outD, 32'h2233_4455);

    // Mid-cycle asynchronous reset, away from any edge
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", bus.outD, 32'h0);
    hist_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    check("after_async_clear", bus.outD, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Random traffic with occasional async resets
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        #1;
        check("rand_async_clear", bus.outD, 32'h0);
        hist_q.delete();
        rst = 1'b1;
        #1;
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    bus.WR1D = 1'b0; bus.WR2D = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
